// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU operations, the
// redirect-suppression state type and small decode helpers.
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  typedef enum logic {
    SENT_IDLE = 1'b0,
    SENT_SENT = 1'b1
  } sent_state_t;

  // A write to x0 never produces a forwardable value.
  function automatic logic fwd_hit(input logic en, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return en && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic alu_op_t alu_op_decode(input logic [2:0] f3,
                                            input logic alt_sub,
                                            input logic alt_sra);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = alt_sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt_sra ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// E-stage inputs, forwarding sources and E/M register outputs of ex_stage.
// Inputs are sampled every cycle; the E/M outputs advance only on edges with hold=0.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  import rv32i_pkg::*;

  logic [XLEN-1:0] PC_E;
  logic [XLEN-1:0] rs1_E;
  logic [XLEN-1:0] rs2_E;
  logic [XLEN-1:0] Imm_E;
  logic [31:0]     IR_E;
  logic            valid_E;
  logic            hold;

  logic            fwd_M_en;
  logic [4:0]      fwd_M_rd;
  logic [XLEN-1:0] fwd_M_data;
  logic            fwd_W_en;
  logic [4:0]      fwd_W_rd;
  logic [XLEN-1:0] fwd_W_data;

  logic [XLEN-1:0] ALU_M;
  logic [XLEN-1:0] rs2_M;
  logic [31:0]     IR_M;
  logic [XLEN-1:0] PC_M;
  logic            valid_M;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  sent_state_t     sent_state;

  modport master (
    output PC_E, rs1_E, rs2_E, Imm_E, IR_E, valid_E, hold,
    output fwd_M_en, fwd_M_rd, fwd_M_data, fwd_W_en, fwd_W_rd, fwd_W_data,
    input  ALU_M, rs2_M, IR_M, PC_M, valid_M, br_taken, br_target, sent_state
  );

  modport slave (
    input  PC_E, rs1_E, rs2_E, Imm_E, IR_E, valid_E, hold,
    input  fwd_M_en, fwd_M_rd, fwd_M_data, fwd_W_en, fwd_W_rd, fwd_W_data,
    output ALU_M, rs2_M, IR_M, PC_M, valid_M, br_taken, br_target, sent_state
  );

endinterface

// File: rtl/rv32_alu.sv
// Combinational RV32I integer ALU; shifts use b[4:0] as the amount.
module rv32_alu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU/address/link result, branch
// resolution with one-shot redirect, and the E/M pipeline register.
module ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign opcode  = bus.IR_E[6:0];
  assign funct3  = bus.IR_E[14:12];
  assign alt     = bus.IR_E[30];
  assign rs1_idx = bus.IR_E[19:15];
  assign rs2_idx = bus.IR_E[24:20];

  // M is the younger producer, so it wins over W on the same register.
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    rs1_fwd = bus.rs1_E;
    if (fwd_hit(bus.fwd_M_en, bus.fwd_M_rd, rs1_idx))      rs1_fwd = bus.fwd_M_data;
    else if (fwd_hit(bus.fwd_W_en, bus.fwd_W_rd, rs1_idx)) rs1_fwd = bus.fwd_W_data;
  end

  always_comb begin
    rs2_fwd = bus.rs2_E;
    if (fwd_hit(bus.fwd_M_en, bus.fwd_M_rd, rs2_idx))      rs2_fwd = bus.fwd_M_data;
    else if (fwd_hit(bus.fwd_W_en, bus.fwd_W_rd, rs2_idx)) rs2_fwd = bus.fwd_W_data;
  end

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  alu_op_t         alu_op;
  logic            res_zero;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] result_e;

  always_comb begin
    alu_a    = rs1_fwd;
    alu_b    = rs2_fwd;
    alu_op   = ALU_ADD;
    res_zero = 1'b0;
    case (opcode)
      OP:     alu_op = alu_op_decode(funct3, alt, alt);
      OP_IMM: begin
        alu_b  = bus.Imm_E;
        alu_op = alu_op_decode(funct3, 1'b0, alt);
      end
      LUI: begin
        alu_a = '0;
        alu_b = bus.Imm_E;
      end
      AUIPC: begin
        alu_a = bus.PC_E;
        alu_b = bus.Imm_E;
      end
      LOAD, STORE: alu_b = bus.Imm_E;
      JAL, JALR: begin
        alu_a = bus.PC_E;
        alu_b = XLEN'(4);
      end
      default: res_zero = 1'b1;
    endcase
  end

  rv32_alu #(.XLEN(XLEN)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  assign result_e = res_zero ? '0 : alu_result;

  logic            br_cond;
  logic            ctrl_xfer;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] br_target_c;

  assign jalr_sum = rs1_fwd + bus.Imm_E;

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
      F3_BNE:  br_cond = (rs1_fwd != rs2_fwd);
      F3_BLT:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      F3_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      F3_BLTU: br_cond = (rs1_fwd <  rs2_fwd);
      F3_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    br_target_c = '0;
    case (opcode)
      BRANCH, JAL: br_target_c = bus.PC_E + bus.Imm_E;
      JALR:        br_target_c = {jalr_sum[XLEN-1:1], 1'b0};
      default:     br_target_c = '0;
    endcase
  end

  assign ctrl_xfer = (opcode == JAL) || (opcode == JALR) ||
                     ((opcode == BRANCH) && br_cond);

  // Once a redirect has been seen under hold, stay quiet until E advances.
  sent_state_t state_q;
  sent_state_t state_d;
  logic        br_taken_c;

  assign br_taken_c = bus.valid_E && ctrl_xfer && (state_q == SENT_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SENT_IDLE: if (br_taken_c && bus.hold) state_d = SENT_SENT;
      SENT_SENT: if (!bus.hold)              state_d = SENT_IDLE;
      default:                               state_d = SENT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SENT_IDLE;
    else     state_q <= state_d;
  end

  logic [XLEN-1:0] alu_m_q, alu_m_d;
  logic [XLEN-1:0] rs2_m_q, rs2_m_d;
  logic [31:0]     ir_m_q,  ir_m_d;
  logic [XLEN-1:0] pc_m_q,  pc_m_d;
  logic            valid_m_q, valid_m_d;

  always_comb begin
    alu_m_d   = alu_m_q;
    rs2_m_d   = rs2_m_q;
    ir_m_d    = ir_m_q;
    pc_m_d    = pc_m_q;
    valid_m_d = valid_m_q;
    if (!bus.hold) begin
      if (bus.valid_E) begin
        alu_m_d   = result_e;
        rs2_m_d   = rs2_fwd;
        ir_m_d    = bus.IR_E;
        pc_m_d    = bus.PC_E;
        valid_m_d = 1'b1;
      end else begin
        alu_m_d   = '0;
        rs2_m_d   = '0;
        ir_m_d    = '0;
        pc_m_d    = '0;
        valid_m_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_m_q   <= '0;
      rs2_m_q   <= '0;
      ir_m_q    <= '0;
      pc_m_q    <= '0;
      valid_m_q <= 1'b0;
    end else begin
      alu_m_q   <= alu_m_d;
      rs2_m_q   <= rs2_m_d;
      ir_m_q    <= ir_m_d;
      pc_m_q    <= pc_m_d;
      valid_m_q <= valid_m_d;
    end
  end

  assign bus.ALU_M      = alu_m_q;
  assign bus.rs2_M      = rs2_m_q;
  assign bus.IR_M       = ir_m_q;
  assign bus.PC_M       = pc_m_q;
  assign bus.valid_M    = valid_m_q;
  assign bus.br_taken   = br_taken_c;
  assign bus.br_target  = br_target_c;
  assign bus.sent_state = state_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_ex_stage;
  import rv32i_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_e(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic v);
    bus.IR_E = ir; bus.PC_E = pc; bus.rs1_E = r1; bus.rs2_E = r2;
    bus.Imm_E = imm; bus.valid_E = v;
  endtask

  task automatic drive_fwd(input logic m_en, input logic [4:0] m_rd, input logic [31:0] m_d,
                           input logic w_en, input logic [4:0] w_rd, input logic [31:0] w_d);
    bus.fwd_M_en = m_en; bus.fwd_M_rd = m_rd; bus.fwd_M_data = m_d;
    bus.fwd_W_en = w_en; bus.fwd_W_rd = w_rd; bus.fwd_W_data = w_d;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic a30,
                                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {1'b0, a30, 5'b0, rs2, rs1, f3, rd, opc};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_ref(input logic [4:0] idx, input logic [31:0] raw);
    if (bus.fwd_M_en && bus.fwd_M_rd != 0 && bus.fwd_M_rd == idx) return bus.fwd_M_data;
    if (bus.fwd_W_en && bus.fwd_W_rd != 0 && bus.fwd_W_rd == idx) return bus.fwd_W_data;
    return raw;
  endfunction

  task automatic model_exec(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm,
                            output logic [31:0] res, output logic xfer, output logic [31:0] tgt);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] bb;
    logic [31:0] sum;
    int          sh;
    opc = ir[6:0]; f3 = ir[14:12];
    res = 0; xfer = 0; tgt = 0;
    case (opc)
      7'h33, 7'h13: begin
        bb = (opc == 7'h33) ? b : imm;
        sh = int'(bb % 32);
        case (f3)
          3'd0: res = (opc == 7'h33 && ir[30]) ? a - bb : a + bb;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
          3'd3: res = (a < bb) ? 32'd1 : 32'd0;
          3'd4: res = a ^ bb;
          3'd5: res = ir[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: res = a | bb;
          default: res = a & bb;
        endcase
      end
      7'h37: res = imm;
      7'h17: res = pc + imm;
      7'h03, 7'h23: res = a + imm;
      7'h6f: begin res = pc + 4; xfer = 1; tgt = pc + imm; end
      7'h67: begin sum = a + imm; res = pc + 4; xfer = 1; tgt = sum & 32'hFFFF_FFFE; end
      7'h63: begin
        tgt = pc + imm;
        case (f3)
          3'd0: xfer = (a == b);
          3'd1: xfer = (a != b);
          3'd4: xfer = ($signed(a) < $signed(b));
          3'd5: xfer = ($signed(a) >= $signed(b));
          3'd6: xfer = (a < b);
          3'd7: xfer = (a >= b);
          default: xfer = 0;
        endcase
      end
      default: res = 0;
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.hold = 1'b0;
    drive_fwd(0, 0, 0, 0, 0, 0);
    drive_e(enc(7'h6f, 0, 0, 0, 0, 1), 32'h80, 0, 0, 32'h10, 1);
    @(posedge clk); #1;
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken got %b exp 0", bus.br_taken); end
    checks++; if (bus.valid_M !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_M); end
    checks++; if ({bus.ALU_M, bus.rs2_M, bus.IR_M, bus.PC_M} !== 128'd0) begin
      errors++; $display("FAIL reset_regs got %h %h %h %h exp 0", bus.ALU_M, bus.rs2_M, bus.IR_M, bus.PC_M);
    end
    bus.valid_E = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] ir;
    ir = enc(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
    drive_fwd(0, 0, 0, 0, 0, 0);
    drive_e(ir, 32'h10, 32'd5, 32'd7, 0, 1);
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'd12) begin errors++; $display("FAIL add_alu got %0d exp 12", bus.ALU_M); end
    checks++; if (bus.valid_M !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.valid_M); end
    checks++; if (bus.IR_M !== ir || bus.PC_M !== 32'h10) begin
      errors++; $display("FAIL add_ir_pc got %h %h exp %h 10", bus.IR_M, bus.PC_M, ir);
    end
  endtask

  task automatic test_forward();
    drive_e(enc(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4), 32'h20, 32'd999, 32'd30, 0, 1);
    drive_fwd(1, 5'd1, 32'd100, 1, 5'd1, 32'd50);
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'd70) begin errors++; $display("FAIL fwd_m_prio got %0d exp 70", bus.ALU_M); end
    drive_e(enc(7'h33, 3'd0, 1'b1, 5'd0, 5'd2, 5'd4), 32'h24, 32'd200, 32'd30, 0, 1);
    drive_fwd(1, 5'd0, 32'd100, 1, 5'd0, 32'd50);
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'd170) begin errors++; $display("FAIL fwd_x0 got %0d exp 170", bus.ALU_M); end
    drive_e(enc(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4), 32'h28, 32'd999, 32'd30, 0, 1);
    drive_fwd(1, 5'd5, 32'd100, 1, 5'd1, 32'd50);
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'd20) begin errors++; $display("FAIL fwd_w got %0d exp 20", bus.ALU_M); end
    drive_e(enc(7'h23, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0), 32'h2c, 32'h1000, 32'd1, 32'd8, 1);
    drive_fwd(1, 5'd2, 32'hABCD, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'h1008 || bus.rs2_M !== 32'hABCD) begin
      errors++; $display("FAIL fwd_store got %h %h exp 1008 abcd", bus.ALU_M, bus.rs2_M);
    end
    drive_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    drive_e(enc(7'h63, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0), 32'h100, 32'h55, 32'h55, 32'hFFFF_FFF8, 1);
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'hF8) begin
      errors++; $display("FAIL beq_redirect got %b %h exp 1 f8", bus.br_taken, bus.br_target);
    end
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'd0 || bus.valid_M !== 1'b1) begin
      errors++; $display("FAIL beq_result got %h %b exp 0 1", bus.ALU_M, bus.valid_M);
    end
    drive_e(enc(7'h63, 3'd6, 1'b0, 5'd1, 5'd2, 5'd0), 32'h104, 32'hFFFF_FFFF, 32'd1, 32'h40, 1);
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken got %b exp 0", bus.br_taken); end
    @(posedge clk); #1;
    drive_e(enc(7'h63, 3'd4, 1'b0, 5'd1, 5'd2, 5'd0), 32'h108, 32'hFFFF_FFFF, 32'd1, 32'h40, 1);
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h148) begin
      errors++; $display("FAIL blt_redirect got %b %h exp 1 148", bus.br_taken, bus.br_target);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jalr();
    drive_e(enc(7'h67, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1), 32'h40, 32'h1003, 0, 32'd4, 1);
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h1006) begin
      errors++; $display("FAIL jalr_redirect got %b %h exp 1 1006", bus.br_taken, bus.br_target);
    end
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'h44) begin errors++; $display("FAIL jalr_link got %h exp 44", bus.ALU_M); end
  endtask

  task automatic test_hold_jal();
    logic [31:0] old_alu, old_ir;
    logic [31:0] jal_ir;
    old_alu = 32'h44;
    old_ir  = enc(7'h67, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1);
    jal_ir  = enc(7'h6f, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1);
    drive_e(jal_ir, 32'h200, 0, 0, 32'h20, 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.br_taken !== (i == 0)) begin
        errors++; $display("FAIL hold_pulse cycle %0d got %b exp %b", i, bus.br_taken, (i == 0));
      end
      if (i > 0) begin
        checks++; if (bus.sent_state !== SENT_SENT) begin
          errors++; $display("FAIL hold_state cycle %0d got %b exp 1", i, bus.sent_state);
        end
      end
      @(posedge clk); #1;
      checks++; if (bus.ALU_M !== old_alu || bus.IR_M !== old_ir || bus.PC_M !== 32'h40) begin
        errors++; $display("FAIL hold_frozen cycle %0d got %h %h %h exp %h %h 40", i, bus.ALU_M, bus.IR_M, bus.PC_M, old_alu, old_ir);
      end
    end
    bus.hold = 1'b0;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL hold_release_pulse got %b exp 0", bus.br_taken); end
    @(posedge clk); #1;
    checks++; if (bus.ALU_M !== 32'h204 || bus.PC_M !== 32'h200 || bus.IR_M !== jal_ir || bus.valid_M !== 1'b1) begin
      errors++; $display("FAIL hold_capture got %h %h %h %b exp 204 200 %h 1", bus.ALU_M, bus.PC_M, bus.IR_M, bus.valid_M, jal_ir);
    end
    bus.valid_E = 1'b0;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bubble_pulse got %b exp 0", bus.br_taken); end
    @(posedge clk); #1;
    checks++; if (bus.valid_M !== 1'b0 || bus.IR_M !== 32'd0 || bus.ALU_M !== 32'd0) begin
      errors++; $display("FAIL bubble got %b %h %h exp 0 0 0", bus.valid_M, bus.IR_M, bus.ALU_M);
    end
  endtask

  task automatic test_rst_mid_hold();
    drive_e(enc(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd2), 32'h300, 32'd9, 0, 32'd1, 1);
    @(posedge clk); #1;
    checks++; if (bus.valid_M !== 1'b1 || bus.ALU_M !== 32'd10) begin
      errors++; $display("FAIL pre_rst got %b %0d exp 1 10", bus.valid_M, bus.ALU_M);
    end
    drive_e(enc(7'h6f, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1), 32'h304, 0, 0, 32'h100, 1);
    bus.hold = 1'b1;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL rst_hold_pulse got %b exp 1", bus.br_taken); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.br_taken !== 1'b0 || bus.valid_M !== 1'b0) begin
      errors++; $display("FAIL rst_async_ctl got %b %b exp 0 0", bus.br_taken, bus.valid_M);
    end
    checks++; if ({bus.ALU_M, bus.rs2_M, bus.IR_M, bus.PC_M} !== 128'd0) begin
      errors++; $display("FAIL rst_async_regs got %h %h %h %h exp 0", bus.ALU_M, bus.rs2_M, bus.IR_M, bus.PC_M);
    end
    bus.valid_E = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.br_taken !== 1'b0 || bus.sent_state !== SENT_IDLE) begin
      errors++; $display("FAIL rst_no_replay got %b %b exp 0 0", bus.br_taken, bus.sent_state);
    end
    bus.hold = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.valid_M !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %b exp 0", bus.valid_M); end
  endtask

  task automatic test_random();
    logic [6:0]  opc_tab[10];
    logic [6:0]  opc;
    logic [31:0] ir, pc, r1, r2, imm, a, b, res, tgt;
    logic [31:0] e_alu, e_rs2, e_ir, e_pc;
    logic        xfer, v, e_valid;
    opc_tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7f};
    bus.hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      opc = opc_tab[$urandom_range(0, 9)];
      ir  = enc(opc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      pc  = $urandom & 32'hFFFF_FFFC;
      r1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      v   = ($urandom_range(0, 7) != 0);
      drive_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      drive_e(ir, pc, r1, r2, imm, v);
      a = fwd_ref(ir[19:15], r1);
      b = fwd_ref(ir[24:20], r2);
      model_exec(ir, pc, a, b, imm, res, xfer, tgt);
      e_valid = v;
      e_alu = v ? res : 32'd0;
      e_rs2 = v ? b : 32'd0;
      e_ir  = v ? ir : 32'd0;
      e_pc  = v ? pc : 32'd0;
      @(negedge clk);
      checks++; if (bus.br_taken !== (v && xfer)) begin
        errors++; $display("FAIL rnd_taken n=%0d ir=%h got %b exp %b", n, ir, bus.br_taken, v && xfer);
      end
      checks++; if (bus.br_target !== tgt) begin
        errors++; $display("FAIL rnd_target n=%0d ir=%h got %h exp %h", n, ir, bus.br_target, tgt);
      end
      @(posedge clk); #1;
      checks++; if (bus.ALU_M !== e_alu || bus.rs2_M !== e_rs2) begin
        errors++; $display("FAIL rnd_data n=%0d ir=%h got %h %h exp %h %h", n, ir, bus.ALU_M, bus.rs2_M, e_alu, e_rs2);
      end
      checks++; if (bus.IR_M !== e_ir || bus.PC_M !== e_pc || bus.valid_M !== e_valid) begin
        errors++; $display("FAIL rnd_ctl n=%0d got %h %h %b exp %h %h %b", n, bus.IR_M, bus.PC_M, bus.valid_M, e_ir, e_pc, e_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_jalr();
    test_hold_jal();
    test_rst_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
